// File: rtl/stack_unit_if.sv
// Stack control/data bundle between the instruction decoder and the LIFO.
// master: decoder side (drives requests/din); slave: stack side (drives dout/status).
interface stack_unit_if #(
    parameter int WIDTH = 16,
    parameter int PTR_W = 5
);
    logic             stack_en;
    logic             stack_rw;
    logic             stack_rst;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [PTR_W-1:0] sp;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output stack_en, stack_rw, stack_rst, din,
        input  dout, sp, empty, full, overflow, underflow
    );

    modport slave (
        input  stack_en, stack_rw, stack_rst, din,
        output dout, sp, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_unit.sv
// Hardware LIFO for PSH/POP/STP: level-sensitive push, edge-qualified pop.
// Ports: CLK, RST_n (sync, active-low), bus (stack_unit_if.slave).
module stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int PTR_W = 5
) (
    input  logic        CLK,
    input  logic        RST_n,
    stack_unit_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] sp_q;
    logic [WIDTH-1:0] dout_q;
    logic             ovf_q;
    logic             unf_q;
    logic             pop_d;

    logic             is_empty;
    logic             is_full;
    logic             push_req;
    logic             pop_hold;
    logic             pop_req;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == PTR_W'(DEPTH));
    assign push_req = bus.stack_en & ~bus.stack_rw;
    assign pop_hold = bus.stack_en & bus.stack_rw;
    // The decoder holds a POP for two cycles; only its first edge pops.
    assign pop_req  = pop_hold & ~pop_d;
    assign wr_idx   = AW'(sp_q);
    assign rd_idx   = AW'(sp_q - PTR_W'(1));

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            sp_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            pop_d  <= 1'b0;
        end else if (bus.stack_rst) begin
            sp_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            // Keeps a held pop from re-firing once the clear is released.
            pop_d  <= pop_hold;
        end else begin
            pop_d <= pop_hold;
            if (push_req) begin
                if (is_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    sp_q <= sp_q + PTR_W'(1);
                end
            end else if (pop_req) begin
                if (is_empty) begin
                    dout_q <= '0;
                    unf_q  <= 1'b1;
                end else begin
                    dout_q <= mem[rd_idx];
                    sp_q   <= sp_q - PTR_W'(1);
                end
            end
        end
    end

    // Storage is not cleared by reset.
    always_ff @(posedge CLK) begin
        if (RST_n && !bus.stack_rst && push_req && !is_full) begin
            mem[wr_idx] <= bus.din;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.sp        = sp_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_stack_unit.sv
// Directed testbench for stack_unit.
// Each scenario task drives stimulus and checks outputs inline.
module tb_stack_unit;
    logic CLK;
    logic RST_n;
    int   total;
    int   bad;

    stack_unit_if #(.WIDTH(16), .PTR_W(5)) bus ();

    stack_unit #(.WIDTH(16), .DEPTH(16), .PTR_W(5)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.stack_en  = 1'b0;
        bus.stack_rw  = 1'b0;
        bus.stack_rst = 1'b0;
        tick();
    endtask

    task automatic push(input logic [15:0] v);
        bus.stack_en = 1'b1;
        bus.stack_rw = 1'b0;
        bus.din      = v;
        tick();
        bus.stack_en = 1'b0;
    endtask

    // Full decoder POP: two held cycles, then one idle cycle.
    task automatic pop2(output logic [15:0] d);
        bus.stack_en = 1'b1;
        bus.stack_rw = 1'b1;
        tick();
        d = bus.dout;
        tick();
        idle();
    endtask

    task automatic clear();
        bus.stack_rst = 1'b1;
        tick();
        bus.stack_rst = 1'b0;
    endtask

    task automatic test_reset();
        RST_n         = 1'b0;
        bus.stack_en  = 1'b0;
        bus.stack_rw  = 1'b0;
        bus.stack_rst = 1'b0;
        bus.din       = '0;
        tick();
        tick();
        RST_n = 1'b1;
        total++;
        if (bus.sp !== 5'd0 || bus.dout !== 16'h0) begin
            bad++;
            $display("FAIL reset_sp_dout got sp=%0d dout=%h exp 0/0", bus.sp, bus.dout);
        end
        total++;
        if ({bus.empty, bus.full, bus.overflow, bus.underflow} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags got %b%b%b%b exp 1000",
                     bus.empty, bus.full, bus.overflow, bus.underflow);
        end
    endtask

    task automatic test_lifo();
        logic [15:0] d;
        logic [15:0] exp_v [3];
        exp_v[0] = 16'h3333;
        exp_v[1] = 16'h2222;
        exp_v[2] = 16'h1111;
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        idle();
        total++;
        if (bus.sp !== 5'd3) begin
            bad++;
            $display("FAIL lifo_sp3 got=%0d exp=3", bus.sp);
        end
        for (int i = 0; i < 3; i++) begin
            pop2(d);
            total++;
            if (d !== exp_v[i]) begin
                bad++;
                $display("FAIL lifo_pop%0d got=%h exp=%h", i, d, exp_v[i]);
            end
            total++;
            if (bus.sp !== 5'(2 - i)) begin
                bad++;
                $display("FAIL lifo_sp_after%0d got=%0d exp=%0d", i, bus.sp, 2 - i);
            end
        end
        total++;
        if (bus.empty !== 1'b1 || bus.underflow !== 1'b0) begin
            bad++;
            $display("FAIL lifo_end got empty=%b unf=%b exp 1/0", bus.empty, bus.underflow);
        end
    endtask

    task automatic test_held_pop();
        push(16'hABCD);
        bus.stack_en = 1'b1;
        bus.stack_rw = 1'b1;
        tick();
        total++;
        if (bus.dout !== 16'hABCD || bus.sp !== 5'd0) begin
            bad++;
            $display("FAIL held_first got dout=%h sp=%0d exp abcd/0", bus.dout, bus.sp);
        end
        tick();
        total++;
        if (bus.sp !== 5'd0 || bus.underflow !== 1'b0 || bus.dout !== 16'hABCD) begin
            bad++;
            $display("FAIL held_second got sp=%0d unf=%b dout=%h exp 0/0/abcd",
                     bus.sp, bus.underflow, bus.dout);
        end
        idle();
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        for (int i = 0; i < 16; i++) push(16'(i));
        total++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_fill got full=%b ovf=%b exp 1/0", bus.full, bus.overflow);
        end
        push(16'hFFFF);
        total++;
        if (bus.full !== 1'b1 || bus.sp !== 5'd16 || bus.overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_push got full=%b sp=%0d ovf=%b exp 1/16/1",
                     bus.full, bus.sp, bus.overflow);
        end
        pop2(d);
        total++;
        if (d !== 16'd15 || bus.sp !== 5'd15) begin
            bad++;
            $display("FAIL ovf_pop got dout=%h sp=%0d exp 000f/15", d, bus.sp);
        end
    endtask

    task automatic test_underflow();
        logic [15:0] d;
        clear();
        pop2(d);
        total++;
        if (d !== 16'h0 || bus.sp !== 5'd0 || bus.underflow !== 1'b1) begin
            bad++;
            $display("FAIL unf_empty got dout=%h sp=%0d unf=%b exp 0/0/1",
                     d, bus.sp, bus.underflow);
        end
        push(16'h0042);
        pop2(d);
        total++;
        if (d !== 16'h0042 || bus.underflow !== 1'b1) begin
            bad++;
            $display("FAIL unf_recover got dout=%h unf=%b exp 0042/1", d, bus.underflow);
        end
    endtask

    task automatic test_stack_rst();
        logic [15:0] d;
        clear();
        for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i));
        push(16'hEEEE);
        for (int i = 0; i < 11; i++) pop2(d);
        total++;
        if (bus.sp !== 5'd5 || bus.overflow !== 1'b1 || d !== 16'h0105) begin
            bad++;
            $display("FAIL stp_setup got sp=%0d ovf=%b dout=%h exp 5/1/0105",
                     bus.sp, bus.overflow, d);
        end
        bus.stack_rst = 1'b1;
        bus.stack_en  = 1'b1;
        bus.stack_rw  = 1'b0;
        bus.din       = 16'h7777;
        tick();
        idle();
        total++;
        if (bus.sp !== 5'd0 || bus.overflow !== 1'b0 || bus.dout !== 16'h0) begin
            bad++;
            $display("FAIL stp_clear got sp=%0d ovf=%b dout=%h exp 0/0/0",
                     bus.sp, bus.overflow, bus.dout);
        end
        pop2(d);
        total++;
        if (bus.underflow !== 1'b1 || d !== 16'h0) begin
            bad++;
            $display("FAIL stp_pop got unf=%b dout=%h exp 1/0", bus.underflow, d);
        end
        // Clear during the first edge of a held pop: continuation must not pop.
        clear();
        push(16'h0055);
        bus.stack_rst = 1'b1;
        bus.stack_en  = 1'b1;
        bus.stack_rw  = 1'b1;
        tick();
        bus.stack_rst = 1'b0;
        push(16'h0066);
        bus.stack_en = 1'b1;
        bus.stack_rw = 1'b1;
        tick();
        total++;
        if (bus.sp !== 5'd0 || bus.dout !== 16'h0066 || bus.underflow !== 1'b0) begin
            bad++;
            $display("FAIL stp_held got sp=%0d dout=%h unf=%b exp 0/0066/0",
                     bus.sp, bus.dout, bus.underflow);
        end
        idle();
    endtask

    task automatic test_rst_held_pop();
        clear();
        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        bus.stack_en = 1'b1;
        bus.stack_rw = 1'b1;
        RST_n        = 1'b0;
        tick();
        total++;
        if (bus.sp !== 5'd0 || bus.dout !== 16'h0 || bus.empty !== 1'b1 ||
            bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            bad++;
            $display("FAIL rst_held got sp=%0d dout=%h e=%b f=%b o=%b u=%b exp reset",
                     bus.sp, bus.dout, bus.empty, bus.full, bus.overflow, bus.underflow);
        end
        RST_n = 1'b1;
        tick();
        total++;
        if (bus.underflow !== 1'b1 || bus.sp !== 5'd0 || bus.dout !== 16'h0) begin
            bad++;
            $display("FAIL rst_repop got unf=%b sp=%0d dout=%h exp 1/0/0",
                     bus.underflow, bus.sp, bus.dout);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        clear();
        push(16'h1234);
        push(16'h5678);
        bus.stack_en = 1'b1;
        bus.stack_rw = 1'b1;
        tick();
        total++;
        if (bus.dout !== 16'h5678 || bus.sp !== 5'd1) begin
            bad++;
            $display("FAIL b2b_first got dout=%h sp=%0d exp 5678/1", bus.dout, bus.sp);
        end
        bus.stack_rw = 1'b0;
        bus.din      = 16'h9ABC;
        tick();
        bus.stack_rw = 1'b1;
        tick();
        total++;
        if (bus.dout !== 16'h9ABC || bus.sp !== 5'd1) begin
            bad++;
            $display("FAIL b2b_push_pop got dout=%h sp=%0d exp 9abc/1", bus.dout, bus.sp);
        end
        idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_lifo();
        test_held_pop();
        test_overflow();
        test_underflow();
        test_stack_rst();
        test_rst_held_pop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
